// File: rtl/atd_deserializer.sv
// ATD serial link receive front end: synchroniser, edge strobe,
// word assembly and idle-bus timeout.
module atd_deserializer #(
  parameter int NUM_BITS       = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CW = $clog2(NUM_BITS + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                ATD_clk,
  input  logic                ATD_data,
  input  logic [1:0]          edge_mode,
  output logic                ATD_shift_enable,
  output logic [NUM_BITS-1:0] rx_word,
  output logic                word_valid,
  output logic                timeout_err,
  output logic [CW-1:0]       bit_count
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] sdat_q;
  logic                 clk_prev_q;
  logic [NUM_BITS-1:0]  shift_q;
  logic [NUM_BITS-1:0]  shift_d;
  logic [NUM_BITS-1:0]  rx_word_q;
  logic [CW-1:0]        cnt_q;
  logic [TW-1:0]        tmo_q;
  logic                 word_valid_q;
  logic                 timeout_err_q;
  logic                 sync_clk;
  logic                 sync_data;
  logic                 rise;
  logic                 fall;
  logic                 strobe;

  // Idle-high bus: synchronisers come out of reset at 1
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_q     <= '1;
      sdat_q     <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], ATD_clk};
      sdat_q     <= {sdat_q[SYNC_STAGES-2:0], ATD_data};
      clk_prev_q <= sync_clk;
    end
  end

  assign sync_clk  = sclk_q[SYNC_STAGES-1];
  assign sync_data = sdat_q[SYNC_STAGES-1];
  assign rise      = sync_clk & ~clk_prev_q;
  assign fall      = ~sync_clk & clk_prev_q;

  always_comb begin
    strobe = 1'b0;
    unique case (edge_mode)
      2'b00: strobe = rise;
      2'b01: strobe = fall;
      2'b10: strobe = rise | fall;
      2'b11: strobe = 1'b0;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST != 0)
      shift_d = {shift_q[NUM_BITS-2:0], sync_data};
    else
      shift_d = {sync_data, shift_q[NUM_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      rx_word_q     <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      word_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      word_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (strobe) begin
            shift_q <= shift_d;
            cnt_q   <= CW'(1);
            state_q <= RECV;
          end
        end
        RECV: begin
          // A strobe beats a timeout landing in the same cycle
          if (strobe) begin
            tmo_q <= '0;
            if (cnt_q == CW'(NUM_BITS - 1)) begin
              rx_word_q    <= shift_d;
              word_valid_q <= 1'b1;
              shift_q      <= '0;
              cnt_q        <= '0;
              state_q      <= IDLE;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            shift_q       <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      endcase
    end
  end

  assign ATD_shift_enable = strobe;
  assign rx_word          = rx_word_q;
  assign word_valid       = word_valid_q;
  assign timeout_err      = timeout_err_q;
  assign bit_count        = cnt_q;

endmodule
